// File: rtl/pipe_pkg.sv
// ------------------------------------------------------------------
// pipe_pkg: state encoding and default widths for pipe_stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'b00;
  localparam state_t ST_FULL  = 2'b01;
  localparam state_t ST_SKID  = 2'b10;

  localparam int CTRL_W_DEFAULT = 14;
  localparam int DATA_W_DEFAULT = 64;
  localparam int CNT_W_DEFAULT  = 16;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ------------------------------------------------------------------
// sat_counter: up-counter that sticks at all-ones; clr beats inc
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage.sv
// ------------------------------------------------------------------
// pipe_stage: valid/ready stage register with 2-entry skid, flush, stall counter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Both handshakes of this cycle are discarded; payload registers keep their contents.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_SKID;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready is a function of state and rst only, so ready paths never chain across stages.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_SKID) & ~rst;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_data  = main_data_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

`default_nettype wire
